// File: rtl/tiny_project_mux.sv
// tiny_project_mux: Wishbone-controlled pad multiplexer hosting N_PROJ tiny projects with guarded switching
//   wb_clk_i, wb_rst_i        clock and synchronous active-high reset
//   wbs_*                     Wishbone slave: CTRL 0x00, RSTLEN 0x04, STATUS 0x08, ERRCLR 0x0C
//   io_in, io_out, io_oeb     pad side (io_oeb active-low)
//   proj_io_in/out/oeb        per-project slices, slice k belongs to project k
//   proj_rst                  per-project reset, active-high
//   user_irq                  [0] pulses on entry to RUN, [2:1] tied low
module tiny_project_mux #(
    parameter int          N_PROJ       = 4,
    parameter int          IO_WIDTH     = 38,
    parameter logic [31:0] BASE_ADR     = 32'h3000_0000,
    parameter int          GUARD_CYCLES = 4
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_i,
    input  logic                         wbs_cyc_i,
    input  logic                         wbs_stb_i,
    input  logic                         wbs_we_i,
    input  logic [3:0]                   wbs_sel_i,
    input  logic [31:0]                  wbs_adr_i,
    input  logic [31:0]                  wbs_dat_i,
    output logic                         wbs_ack_o,
    output logic [31:0]                  wbs_dat_o,
    input  logic [IO_WIDTH-1:0]          io_in,
    output logic [IO_WIDTH-1:0]          io_out,
    output logic [IO_WIDTH-1:0]          io_oeb,
    output logic [N_PROJ*IO_WIDTH-1:0]   proj_io_in,
    input  logic [N_PROJ*IO_WIDTH-1:0]   proj_io_out,
    input  logic [N_PROJ*IO_WIDTH-1:0]   proj_io_oeb,
    output logic [N_PROJ-1:0]            proj_rst,
    output logic [2:0]                   user_irq
);
    typedef enum logic [1:0] {OFF = 2'd0, GUARD = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
    localparam logic [4:0]  NP     = 5'(N_PROJ);
    localparam logic [15:0] G_LOAD = 16'(GUARD_CYCLES - 1);
    state_t      state, state_n;
    logic [3:0]  active, active_n, sel_q, ctrl_sel;
    logic        en_q, ctrl_en, err, err_n, served;
    logic [7:0]  rstlen;
    logic [15:0] cnt, cnt_n, hold_load;
    logic        req, hit, start, wr, ctrl_wr, clr_wr;
    logic [5:0]  idx;
    logic [31:0] rdata;
    logic        unused;
    assign req = wbs_cyc_i & wbs_stb_i;
    assign hit = wbs_adr_i[31:8] == BASE_ADR[31:8];
    assign idx = wbs_adr_i[7:2];
    // served marks a request already acked and still held, so it is never acked twice
    assign start = req & ~wbs_ack_o & ~served;
    // register side effects use the bus values the master holds through the ack cycle
    assign wr = wbs_ack_o & req & wbs_we_i & hit;
    assign ctrl_wr = wr & (idx == 6'd0) & (wbs_sel_i[0] | wbs_sel_i[3]);
    assign clr_wr = wr & (idx == 6'd3) & wbs_sel_i[0];
    assign ctrl_sel = wbs_sel_i[0] ? wbs_dat_i[3:0] : sel_q;
    assign ctrl_en = wbs_sel_i[3] ? wbs_dat_i[31] : en_q;
    assign hold_load = rstlen == 8'd0 ? 16'd0 : {8'd0, rstlen} - 16'd1;
    assign rdata = !hit        ? 32'd0 :
                   idx == 6'd0 ? {en_q, 27'd0, sel_q} :
                   idx == 6'd1 ? {24'd0, rstlen} :
                   idx == 6'd2 ? {23'd0, err, 2'b00, state, active} : 32'd0;
    assign proj_io_in = {N_PROJ{io_in}};
    assign unused = ^{wbs_sel_i[2:1], wbs_dat_i[30:8], wbs_adr_i[1:0]};

    always_comb begin
        state_n = state;
        active_n = active;
        err_n = err;
        cnt_n = cnt - 16'd1;
        if (state == GUARD && cnt == 16'd0) begin
            state_n = HOLD;
            cnt_n = hold_load;
        end
        if (state == HOLD && cnt == 16'd0)
            state_n = RUN;
        // an enable-low write always aborts; a switch is only accepted from OFF or RUN
        if (ctrl_wr) begin
            if (!ctrl_en)
                state_n = OFF;
            else if (state == GUARD || state == HOLD || {1'b0, ctrl_sel} >= NP)
                err_n = 1'b1;
            else begin
                state_n = GUARD;
                active_n = ctrl_sel;
                cnt_n = G_LOAD;
            end
        end
        if (clr_wr)
            err_n = 1'b0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= OFF;
            active <= '0;
            err <= 1'b0;
            cnt <= '0;
        end else begin
            state <= state_n;
            active <= active_n;
            err <= err_n;
            cnt <= cnt_n;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            served <= 1'b0;
            sel_q <= '0;
            en_q <= 1'b0;
            rstlen <= 8'd16;
            proj_rst <= '1;
            user_irq <= '0;
            io_out <= '0;
            io_oeb <= '1;
        end else begin
            wbs_ack_o <= start;
            wbs_dat_o <= (start & ~wbs_we_i) ? rdata : 32'd0;
            served <= req & (served | wbs_ack_o);
            if (ctrl_wr) begin
                sel_q <= ctrl_sel;
                en_q <= ctrl_en;
            end
            if (wr && idx == 6'd1 && wbs_sel_i[0])
                rstlen <= wbs_dat_i[7:0];
            // resets and irq are flopped from the next state so they change with the state register
            proj_rst <= state_n == RUN ? ~(N_PROJ'(1) << active_n) : '1;
            user_irq <= {2'b00, state_n == RUN && state != RUN};
            io_out <= state == RUN ? proj_io_out[active * IO_WIDTH +: IO_WIDTH] : '0;
            io_oeb <= state == RUN ? proj_io_oeb[active * IO_WIDTH +: IO_WIDTH] : '1;
        end
    end
endmodule
